// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage.
//  - funct3 encodings of the load instructions handled by the aligner
//  - W-stage FSM state encoding
//  - packed record of everything latched from the execute stage
package urv_writeback_pkg;

    localparam logic [2:0] FUN_LB  = 3'b000;
    localparam logic [2:0] FUN_LH  = 3'b001;
    localparam logic [2:0] FUN_LW  = 3'b010;
    localparam logic [2:0] FUN_LBU = 3'b100;
    localparam logic [2:0] FUN_LHU = 3'b101;

    typedef enum logic [0:0] {
        W_IDLE      = 1'b0,
        W_LOAD_WAIT = 1'b1
    } w_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        write;
        logic        load;
        logic [2:0]  fun;
        logic [1:0]  addr;
    } w_stage_t;

endpackage

// File: rtl/urv_writeback_if.sv
// Execute -> writeback handshake.
//  x_valid     execute presents an instruction
//  x_rd        destination register
//  x_rd_value  ALU/CSR result (non-load)
//  x_rd_write  instruction writes rd
//  x_load      instruction is a load
//  x_fun       load funct3
//  x_dm_addr   load address bits [1:0]
//  w_stall     writeback cannot accept; execute holds x_* stable
interface urv_writeback_if;
    logic        x_valid;
    logic [4:0]  x_rd;
    logic [31:0] x_rd_value;
    logic        x_rd_write;
    logic        x_load;
    logic [2:0]  x_fun;
    logic [1:0]  x_dm_addr;
    logic        w_stall;

    modport master (
        output x_valid, x_rd, x_rd_value, x_rd_write, x_load, x_fun, x_dm_addr,
        input  w_stall
    );

    modport slave (
        input  x_valid, x_rd, x_rd_value, x_rd_write, x_load, x_fun, x_dm_addr,
        output w_stall
    );
endinterface

// File: rtl/urv_writeback_load_align.sv
// Load data aligner: picks the addressed byte/half of the data-memory word
// and sign- or zero-extends it to 32 bits. Purely combinational.
//  fun_i    load funct3
//  addr_i   address bits [1:0]
//  data_i   raw data-memory word
//  value_o  extended result (0 for funct3 codes that are not loads)
module urv_writeback_load_align
    import urv_writeback_pkg::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        assign byte_lane[gi] = data_i[8*gi +: 8];
    end

    assign sel_byte = byte_lane[addr_i];
    // Halfword alignment is guaranteed upstream, so only addr[1] matters.
    assign sel_half = addr_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        value_o = 32'h0;
        case (fun_i)
            FUN_LB:  value_o = {{24{sel_byte[7]}}, sel_byte};
            FUN_LBU: value_o = {24'h0, sel_byte};
            FUN_LH:  value_o = {{16{sel_half[15]}}, sel_half};
            FUN_LHU: value_o = {16'h0, sel_half};
            FUN_LW:  value_o = data_i;
            default: value_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: registers the execute result, waits for data-memory
// load completion, aligns load data and drives the register-file write port
// and the W-stage bypass. Optional load timeout raises a one-cycle fault.
//  clk_i, rst_n_i          clock, asynchronous active-low reset
//  x_if (slave)            execute-stage instruction + w_stall back-pressure
//  dm_data_l_i             data-memory read word
//  dm_load_done_i          data-memory load complete (1-cycle pulse)
//  rf_rd_o/value/write     register-file write port
//  w_bypass_rd_write/value bypass toward execute (mirrors rf_*)
//  load_fault_o            1-cycle pulse on load timeout
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int G_LOAD_TIMEOUT = 0,
    parameter int G_TMO_WIDTH    = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    urv_writeback_if.slave    x_if,
    input  logic [31:0]       dm_data_l_i,
    input  logic              dm_load_done_i,
    output logic [4:0]        rf_rd_o,
    output logic [31:0]       rf_rd_value_o,
    output logic              rf_rd_write_o,
    output logic              w_bypass_rd_write_o,
    output logic [31:0]       w_bypass_rd_value_o,
    output logic              load_fault_o
);

    localparam logic [G_TMO_WIDTH-1:0] TMO_LAST =
        (G_LOAD_TIMEOUT > 0) ? G_TMO_WIDTH'(G_LOAD_TIMEOUT - 1) : '0;

    w_state_t               state_reg;
    w_stage_t               stage_reg;
    logic                   valid_reg;
    logic [G_TMO_WIDTH-1:0] tmo_cnt_reg;

    logic        in_wait;
    logic        load_done;
    logic        load_tmo;
    logic        w_stall;
    logic        capture;
    logic        stage_write;
    logic [31:0] align_value;
    logic [31:0] wb_value;

    assign in_wait   = (state_reg == W_LOAD_WAIT);
    assign load_done = in_wait && dm_load_done_i;
    // A completing load beats a timeout landing in the same cycle.
    assign load_tmo  = (G_LOAD_TIMEOUT > 0) && in_wait && !dm_load_done_i
                       && (tmo_cnt_reg == TMO_LAST);
    assign w_stall   = in_wait && !dm_load_done_i && !load_tmo;
    assign capture   = x_if.x_valid && !w_stall;

    // Stage register, FSM and timeout counter. Whenever the stage is not
    // stalled it retires its current content and takes whatever execute
    // offers, so a load finishing lets the next instruction in without a
    // bubble (including a following load, which re-enters LOAD_WAIT).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= W_IDLE;
            valid_reg   <= 1'b0;
            stage_reg   <= '0;
            tmo_cnt_reg <= '0;
        end else if (!w_stall) begin
            valid_reg <= x_if.x_valid;
            if (capture) begin
                stage_reg <= '{rd:    x_if.x_rd,
                               value: x_if.x_rd_value,
                               write: x_if.x_rd_write,
                               load:  x_if.x_load,
                               fun:   x_if.x_fun,
                               addr:  x_if.x_dm_addr};
            end
            if (capture && x_if.x_load) begin
                state_reg   <= W_LOAD_WAIT;
                tmo_cnt_reg <= '0;
            end else begin
                state_reg <= W_IDLE;
            end
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    urv_writeback_load_align u_align (
        .fun_i   (stage_reg.fun),
        .addr_i  (stage_reg.addr),
        .data_i  (dm_data_l_i),
        .value_o (align_value)
    );

    // x0 is hard-wired zero: never write or bypass it.
    assign stage_write = valid_reg && stage_reg.write && (stage_reg.rd != 5'd0);
    assign wb_value    = (stage_reg.load && in_wait) ? align_value : stage_reg.value;

    assign x_if.w_stall        = w_stall;
    assign rf_rd_o             = stage_reg.rd;
    assign rf_rd_value_o       = wb_value;
    assign rf_rd_write_o       = stage_write && (!stage_reg.load || load_done);
    assign w_bypass_rd_write_o = rf_rd_write_o;
    assign w_bypass_rd_value_o = wb_value;
    assign load_fault_o        = load_tmo;

endmodule

// File: tb/tb_urv_writeback.sv
module tb_urv_writeback;
    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] dm_data;
    logic        dm_done;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value;
    logic        rf_write;
    logic        byp_write;
    logic [31:0] byp_value;
    logic        fault;

    urv_writeback_if wb_if ();

    urv_writeback #(.G_LOAD_TIMEOUT(TMO), .G_TMO_WIDTH(8)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .x_if                (wb_if),
        .dm_data_l_i         (dm_data),
        .dm_load_done_i      (dm_done),
        .rf_rd_o             (rf_rd),
        .rf_rd_value_o       (rf_value),
        .rf_rd_write_o       (rf_write),
        .w_bypass_rd_write_o (byp_write),
        .w_bypass_rd_value_o (byp_value),
        .load_fault_o        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the instruction currently held in W and how many
    // cycles it has been waiting for its load data.
    logic        m_valid, m_wr, m_ld;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    logic [2:0]  m_fun;
    logic [1:0]  m_addr;
    int          m_wait;
    logic        e_stall, e_write, e_tmo;
    logic [31:0] e_val;

    typedef struct {
        logic [2:0]  fun;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } align_vec_t;

    align_vec_t vecs[13];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_align(logic [2:0] fun, logic [1:0] addr, logic [31:0] data);
        int unsigned b, h;
        b = (data >> (8 * addr)) & 32'hFF;
        h = (data >> (16 * (addr / 2))) & 32'hFFFF;
        case (fun)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return data;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_wr = 1'b0; m_ld = 1'b0; m_rd = 5'd0;
        m_val = 32'h0; m_fun = 3'd0; m_addr = 2'd0; m_wait = 0;
        e_stall = 1'b0;
    endtask

    task automatic drive(logic v, logic [4:0] rd, logic [31:0] val, logic wr,
                         logic ld, logic [2:0] fun, logic [1:0] addr);
        wb_if.x_valid    = v;
        wb_if.x_rd       = rd;
        wb_if.x_rd_value = val;
        wb_if.x_rd_write = wr;
        wb_if.x_load     = ld;
        wb_if.x_fun      = fun;
        wb_if.x_dm_addr  = addr;
    endtask

    // Compare the current cycle against the model (inputs already applied).
    task automatic eval_cycle();
        logic waiting, done;
        #1;
        waiting = m_valid && m_ld;
        done    = waiting && dm_done;
        e_tmo   = waiting && !dm_done && (m_wait == TMO - 1);
        e_stall = waiting && !dm_done && !e_tmo;
        e_write = m_valid && m_wr && (m_rd != 5'd0) && (!m_ld || done);
        e_val   = m_ld ? ref_align(m_fun, m_addr, dm_data) : m_val;
        chk("w_stall", 32'(wb_if.w_stall), 32'(e_stall));
        chk("rf_write", 32'(rf_write), 32'(e_write));
        chk("bypass_write", 32'(byp_write), 32'(e_write));
        chk("load_fault", 32'(fault), 32'(e_tmo));
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        if (e_write) begin
            chk("rf_value", rf_value, e_val);
            chk("bypass_value", byp_value, e_val);
            $display("txn t=%0t rd=%0d value=%h", $time, m_rd, e_val);
        end
    endtask

    task automatic adv_cycle();
        if (!e_stall) begin
            m_valid = wb_if.x_valid;
            if (wb_if.x_valid) begin
                m_rd = wb_if.x_rd; m_val = wb_if.x_rd_value; m_wr = wb_if.x_rd_write;
                m_ld = wb_if.x_load; m_fun = wb_if.x_fun; m_addr = wb_if.x_dm_addr;
                m_wait = 0;
            end
        end else begin
            m_wait++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval_cycle();
        adv_cycle();
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_stall"}, 32'(wb_if.w_stall), 32'h0);
        chk({tag, "_write"}, 32'(rf_write), 32'h0);
        chk({tag, "_bwrite"}, 32'(byp_write), 32'h0);
        chk({tag, "_value"}, rf_value, 32'h0);
        chk({tag, "_bvalue"}, byp_value, 32'h0);
        chk({tag, "_rd"}, 32'(rf_rd), 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
    endtask

    logic [2:0] fun_pool [8];

    initial begin
        vecs[0]  = '{3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1]  = '{3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080};
        vecs[2]  = '{3'b000, 2'd0, 32'h1234_5678, 32'h0000_0078};
        vecs[3]  = '{3'b000, 2'd1, 32'h1234_F678, 32'hFFFF_FFF6};
        vecs[4]  = '{3'b100, 2'd2, 32'h12AB_5678, 32'h0000_00AB};
        vecs[5]  = '{3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001};
        vecs[6]  = '{3'b001, 2'd0, 32'h1234_ABCD, 32'hFFFF_ABCD};
        vecs[7]  = '{3'b101, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD};
        vecs[8]  = '{3'b101, 2'd2, 32'h9ABC_0000, 32'h0000_9ABC};
        vecs[9]  = '{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[10] = '{3'b011, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[11] = '{3'b110, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'b111, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        fun_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};

        // Reset held with a valid ADD on the inputs.
        rst_n = 1'b0; dm_data = 32'hA5A5_A5A5; dm_done = 1'b0;
        drive(1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 3'd0, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();                                   // ADD captured on this edge
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        eval_cycle();
        chk("add_write", 32'(rf_write), 32'h1);
        chk("add_rd", 32'(rf_rd), 32'd5);
        chk("add_value", rf_value, 32'h1234);
        chk("add_bypass", 32'(byp_write), 32'h1);
        adv_cycle();

        // LB from addr 3, done three cycles after capture.
        drive(1'b1, 5'd9, 32'h0, 1'b1, 1'b1, 3'b000, 2'd3);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            chk("lb_stall", 32'(wb_if.w_stall), 32'h1);
            adv_cycle();
        end
        dm_done = 1'b1; dm_data = 32'h80FF_0000;
        eval_cycle();
        chk("lb_value", rf_value, 32'hFFFF_FF80);
        chk("lb_write", 32'(rf_write), 32'h1);
        adv_cycle();
        dm_done = 1'b0;

        // Table of align cases, each a load completing one cycle after capture.
        foreach (vecs[k]) begin
            drive(1'b1, 5'd7, $urandom, 1'b1, 1'b1, vecs[k].fun, vecs[k].addr);
            step();
            drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
            dm_done = 1'b1; dm_data = vecs[k].data;
            eval_cycle();
            chk("vec_value", rf_value, vecs[k].exp);
            adv_cycle();
            dm_done = 1'b0;
        end

        // LH completing while an ADD is offered: ADD follows with no bubble.
        drive(1'b1, 5'd10, 32'h0, 1'b1, 1'b1, 3'b001, 2'd2);
        step();
        drive(1'b1, 5'd11, 32'hCAFE, 1'b1, 1'b0, 3'd0, 2'd0);
        dm_done = 1'b1; dm_data = 32'h8001_5555;
        eval_cycle();
        chk("b2b_lh_value", rf_value, 32'hFFFF_8001);
        adv_cycle();
        dm_done = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        eval_cycle();
        chk("b2b_add_write", 32'(rf_write), 32'h1);
        chk("b2b_add_value", rf_value, 32'hCAFE);
        adv_cycle();

        // Writes to x0 are suppressed; a load to x0 still stalls.
        drive(1'b1, 5'd0, 32'h77, 1'b1, 1'b0, 3'd0, 2'd0);
        step();
        drive(1'b1, 5'd0, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
        eval_cycle();
        chk("x0_add_write", 32'(rf_write), 32'h0);
        adv_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        eval_cycle();
        chk("x0_load_stall", 32'(wb_if.w_stall), 32'h1);
        adv_cycle();
        dm_done = 1'b1;
        eval_cycle();
        chk("x0_load_write", 32'(rf_write), 32'h0);
        adv_cycle();
        dm_done = 1'b0;

        // Timeout: no done -> 3 stall cycles, fault on the 4th.
        drive(1'b1, 5'd12, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            eval_cycle();
            chk("tmo_stall", 32'(wb_if.w_stall), 32'h1);
            adv_cycle();
        end
        eval_cycle();
        chk("tmo_fault", 32'(fault), 32'h1);
        chk("tmo_nowrite", 32'(rf_write), 32'h0);
        adv_cycle();
        dm_done = 1'b1;                           // done in IDLE is ignored
        eval_cycle();
        chk("idle_done_ignored", 32'(rf_write), 32'h0);
        adv_cycle();
        dm_done = 1'b0;

        // Done arriving on the 4th waiting cycle beats the timeout.
        drive(1'b1, 5'd13, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        repeat (3) step();
        dm_done = 1'b1; dm_data = 32'h0BAD_F00D;
        eval_cycle();
        chk("late_done_write", 32'(rf_write), 32'h1);
        chk("late_done_fault", 32'(fault), 32'h0);
        adv_cycle();
        dm_done = 1'b0;

        // Asynchronous reset in the middle of a load.
        drive(1'b1, 5'd14, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();

        // Randomized traffic; x_* held stable while the stage stalls.
        for (int n = 0; n < 600; n++) begin
            if (!e_stall) begin
                drive(($urandom % 10) < 6, 5'($urandom), $urandom, 1'($urandom),
                      1'($urandom), fun_pool[$urandom % 8], 2'($urandom));
            end
            dm_done = ($urandom % 100) < 35;
            dm_data = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
